// File: rtl/betting_round_ctrl_pkg.sv
// Shared poker types: round FSM states, seat/chip widths and a seat-count helper.
package betting_round_ctrl_pkg;

  localparam int MAX_SEATS = 8;
  localparam int CHIP_W    = 10;
  localparam int SEAT_W    = 3;

  localparam logic [CHIP_W-1:0] CHIP_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    WAIT_ACT,
    APPLY,
    DONE
  } round_state_t;

  function automatic logic [3:0] seat_count(input logic [MAX_SEATS-1:0] m);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_SEATS; i++) begin
      cnt = cnt + 4'(m[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/betting_round_ctrl_if.sv
// Action/turn bus between the table front-end (master) and the betting round controller (slave).
interface betting_round_ctrl_if;
  import betting_round_ctrl_pkg::*;

  logic                 start_round;
  logic [SEAT_W-1:0]    first_seat;
  logic [MAX_SEATS-1:0] in_hand;
  logic                 check_or_call;
  logic                 bet_or_raise;
  logic                 fold;
  logic [SEAT_W-1:0]    player_turn;
  logic                 turn_valid;
  logic                 make_bet;
  logic [CHIP_W-1:0]    bet_amount;
  logic [CHIP_W-1:0]    current_bet;
  logic [CHIP_W-1:0]    pot;
  logic [MAX_SEATS-1:0] folded;
  logic                 round_done;
  logic                 hand_won;

  modport master (
    output start_round, first_seat, in_hand, check_or_call, bet_or_raise, fold,
    input  player_turn, turn_valid, make_bet, bet_amount, current_bet, pot,
           folded, round_done, hand_won
  );

  modport slave (
    input  start_round, first_seat, in_hand, check_or_call, bet_or_raise, fold,
    output player_turn, turn_valid, make_bet, bet_amount, current_bet, pot,
           folded, round_done, hand_won
  );

endinterface

// File: rtl/betting_round_ctrl_seat_rr_picker.sv
// Rotating priority encoder: first set mask bit at or after ptr, wrapping 7->0.
module seat_rr_picker
  import betting_round_ctrl_pkg::*;
(
  input  logic [MAX_SEATS-1:0] mask,
  input  logic [SEAT_W-1:0]    ptr,
  output logic [SEAT_W-1:0]    seat,
  output logic                 found
);

  logic [SEAT_W-1:0]    idx [MAX_SEATS];
  logic [MAX_SEATS-1:0] rot_mask;
  logic [SEAT_W-1:0]    offset;

  // rot_mask[k] is the seat k positions after the pointer, so bit 0 has top priority.
  generate
    for (genvar gi = 0; gi < MAX_SEATS; gi++) begin : g_rot
      assign idx[gi]      = ptr + SEAT_W'(gi);
      assign rot_mask[gi] = mask[idx[gi]];
    end
  endgenerate

  always_comb begin
    offset = '0;
    found  = 1'b0;
    for (int i = MAX_SEATS - 1; i >= 0; i--) begin
      if (rot_mask[i]) begin
        offset = SEAT_W'(i);
        found  = 1'b1;
      end
    end
  end

  assign seat = ptr + offset;

endmodule

// File: rtl/betting_round_ctrl.sv
// Betting round controller: sequences turns, applies fold/call/raise, tracks pot and bets.
// Optional BET_TIMEOUT_EN: an idle turn of TIMEOUT_CYCLES is taken as a fold.
module betting_round_ctrl
  import betting_round_ctrl_pkg::*;
#(
  parameter int RAISE_UNIT     = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                 clk,
  input logic                 reset,
  betting_round_ctrl_if.slave bus
);

  round_state_t         state_reg, state_next;
  logic [SEAT_W-1:0]    ptr_reg, seat_reg;
  logic [MAX_SEATS-1:0] in_hand_reg, folded_reg, acted_reg;
  logic [CHIP_W-1:0]    contrib_reg [MAX_SEATS];
  logic [CHIP_W-1:0]    current_bet_reg, pot_reg, bet_amount_reg;

  logic [MAX_SEATS-1:0] remaining, settled, seat_onehot;
  logic [3:0]           remaining_cnt;
  logic [SEAT_W-1:0]    pick_seat;
  logic                 pick_found;
  logic                 timeout_hit;
  logic                 do_fold, do_call, do_raise, accept;
  logic [CHIP_W:0]      raise_sum, pot_sum;
  logic [CHIP_W-1:0]    raise_bet, target_bet, pay;

  assign remaining     = in_hand_reg & ~folded_reg;
  assign remaining_cnt = seat_count(remaining);
  assign seat_onehot   = MAX_SEATS'(1) << seat_reg;

  seat_rr_picker u_picker (
    .mask  (remaining),
    .ptr   (ptr_reg),
    .seat  (pick_seat),
    .found (pick_found)
  );

  generate
    for (genvar gi = 0; gi < MAX_SEATS; gi++) begin : g_settled
      assign settled[gi] = ~remaining[gi] | (acted_reg[gi] & (contrib_reg[gi] == current_bet_reg));
    end
  endgenerate

`ifdef BET_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] timeout_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_cnt_reg <= '0;
    end else if (state_reg == SELECT) begin
      timeout_cnt_reg <= '0;
    end else if (state_reg == WAIT_ACT && !timeout_hit) begin
      timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
    end
  end

  assign timeout_hit = (state_reg == WAIT_ACT) && (timeout_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // A raise at a capped bet cannot move the bet, so it becomes a call.
  always_comb begin
    do_fold  = 1'b0;
    do_call  = 1'b0;
    do_raise = 1'b0;
    if (state_reg == WAIT_ACT) begin
      if (bus.fold || timeout_hit) begin
        do_fold = 1'b1;
      end else if (bus.check_or_call) begin
        do_call = 1'b1;
      end else if (bus.bet_or_raise) begin
        if (current_bet_reg == CHIP_MAX) do_call = 1'b1;
        else                             do_raise = 1'b1;
      end
    end
    accept = do_fold | do_call | do_raise;
  end

  assign raise_sum  = {1'b0, current_bet_reg} + (CHIP_W + 1)'(RAISE_UNIT);
  assign raise_bet  = raise_sum[CHIP_W] ? CHIP_MAX : raise_sum[CHIP_W-1:0];
  assign target_bet = do_raise ? raise_bet : current_bet_reg;
  assign pay        = do_fold ? '0 : target_bet - contrib_reg[seat_reg];
  assign pot_sum    = {1'b0, pot_reg} + {1'b0, pay};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (bus.start_round) state_next = SELECT;
      SELECT:   state_next = (remaining_cnt <= 4'd1 || !pick_found) ? DONE : WAIT_ACT;
      WAIT_ACT: if (accept) state_next = APPLY;
      APPLY:    state_next = (remaining_cnt <= 4'd1 || (&settled)) ? DONE : SELECT;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Pot, contributions and bet all move on the accepting edge, so APPLY sees the new values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg         <= '0;
      seat_reg        <= '0;
      in_hand_reg     <= '0;
      folded_reg      <= '0;
      acted_reg       <= '0;
      current_bet_reg <= '0;
      pot_reg         <= '0;
      bet_amount_reg  <= '0;
      for (int i = 0; i < MAX_SEATS; i++) contrib_reg[i] <= '0;
    end else begin
      if (state_reg == IDLE && bus.start_round) begin
        in_hand_reg     <= bus.in_hand;
        ptr_reg         <= bus.first_seat;
        folded_reg      <= '0;
        acted_reg       <= '0;
        current_bet_reg <= '0;
        for (int i = 0; i < MAX_SEATS; i++) contrib_reg[i] <= '0;
      end
      if (state_reg == SELECT) seat_reg <= pick_seat;
      if (accept) begin
        bet_amount_reg  <= pay;
        pot_reg         <= pot_sum[CHIP_W] ? CHIP_MAX : pot_sum[CHIP_W-1:0];
        current_bet_reg <= target_bet;
        if (do_fold)  folded_reg <= folded_reg | seat_onehot;
        else          contrib_reg[seat_reg] <= target_bet;
        if (do_raise) acted_reg <= seat_onehot;
        else          acted_reg <= acted_reg | seat_onehot;
      end
      if (state_reg == APPLY) ptr_reg <= seat_reg + 1'b1;
    end
  end

  assign bus.player_turn = seat_reg;
  assign bus.turn_valid  = (state_reg == WAIT_ACT);
  assign bus.make_bet    = (state_reg == APPLY) && (bet_amount_reg != '0);
  assign bus.bet_amount  = bet_amount_reg;
  assign bus.current_bet = current_bet_reg;
  assign bus.pot         = pot_reg;
  assign bus.folded      = folded_reg;
  assign bus.round_done  = (state_reg == DONE);
  assign bus.hand_won    = (state_reg == DONE) && (remaining_cnt == 4'd1);

endmodule
